// File: rtl/button_debouncer.sv
// Push-button synchroniser/debouncer with press/release strobes and switch pass-through.
// Optional macro BUTTON_DEBOUNCER_SWITCH_SYNC_EN adds a two-flop synchroniser on switches_in.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned COUNT_WIDTH     = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_n,
    input  logic [17:0] switches_in,
    output logic        button,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic [17:0] switches_out
);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_PENDING,
        ST_PRESSED,
        ST_RELEASE_PENDING
    } state_e;

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] ONE        = COUNT_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   button_q, button_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   key_s1_q, key_s2_q;

    // Synchroniser flops idle high so reset looks like a released key.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_s1_q  <= 1'b1;
            key_s2_q  <= 1'b1;
            state_q   <= ST_RELEASED;
            count_q   <= '0;
            button_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            key_s1_q  <= key_n;
            key_s2_q  <= key_s1_q;
            state_q   <= state_d;
            count_q   <= count_d;
            button_q  <= button_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        button_d  = button_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (!key_s2_q) begin
                    state_d = ST_PRESS_PENDING;
                    count_d = '0;
                end
            end
            ST_PRESS_PENDING: begin
                if (key_s2_q) begin
                    state_d = ST_RELEASED;
                end else if (count_q == LAST_COUNT) begin
                    state_d  = ST_PRESSED;
                    button_d = 1'b1;
                    press_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            ST_PRESSED: begin
                if (key_s2_q) begin
                    state_d = ST_RELEASE_PENDING;
                    count_d = '0;
                end
            end
            ST_RELEASE_PENDING: begin
                if (!key_s2_q) begin
                    state_d = ST_PRESSED;
                end else if (count_q == LAST_COUNT) begin
                    state_d   = ST_RELEASED;
                    button_d  = 1'b0;
                    release_d = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
            end
        endcase
    end

    assign button        = button_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCER_SWITCH_SYNC_EN
    logic [17:0] sw_s1_q, sw_s2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= switches_in;
            sw_s2_q <= sw_s1_q;
        end
    end

    assign switches_out = sw_s2_q;
`else
    assign switches_out = switches_in;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: DEBOUNCE_CYCLES=4 main instance plus a DEBOUNCE_CYCLES=1 instance.
module tb_button_debouncer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_n = 1'b0;
    logic [17:0] switches_in = '0;
    logic        button, press_pulse, release_pulse;
    logic [17:0] switches_out;
    logic        button1, press1, release1;
    logic [17:0] switches_out1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_debouncer #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(3)) dut (
        .clock        (clk),
        .reset        (reset),
        .key_n        (key_n),
        .switches_in  (switches_in),
        .button       (button),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .switches_out (switches_out)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(1), .COUNT_WIDTH(1)) dut1 (
        .clock        (clk),
        .reset        (reset),
        .key_n        (key_n),
        .switches_in  (switches_in),
        .button       (button1),
        .press_pulse  (press1),
        .release_pulse(release1),
        .switches_out (switches_out1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset with key held down
        #1 reset = 1'b1;
        key_n = 1'b0;
        repeat (3) tick();
        check("rst_button", 32'(button), 32'd0);
        check("rst_press", 32'(press_pulse), 32'd0);
        check("rst_release", 32'(release_pulse), 32'd0);
        check("rst_switches", 32'(switches_out), 32'd0);
        check("rst_button1", 32'(button1), 32'd0);

        // Key held through reset release: fresh press after edge 7 (edge 4 for N=1)
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("press_p e%0d", e), 32'(press_pulse), 32'(e == 7));
            check($sformatf("press_b e%0d", e), 32'(button), 32'(e >= 7));
            check($sformatf("n1_p e%0d", e), 32'(press1), 32'(e == 4));
            check($sformatf("n1_b e%0d", e), 32'(button1), 32'(e >= 4));
        end

        // Clean release
        key_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("rel_r e%0d", e), 32'(release_pulse), 32'(e == 7));
            check($sformatf("rel_b e%0d", e), 32'(button), 32'(e < 7));
            check($sformatf("rel_p e%0d", e), 32'(press_pulse), 32'd0);
        end

        // Bounce 0,1,0,1 for 2 cycles each: no strobe
        for (int ph = 0; ph < 4; ph++) begin
            key_n = (ph % 2 == 1);
            for (int c = 0; c < 2; c++) begin
                tick();
                check($sformatf("bnc_p ph%0d", ph), 32'(press_pulse), 32'd0);
                check($sformatf("bnc_b ph%0d", ph), 32'(button), 32'd0);
            end
        end
        key_n = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("bnc_fp e%0d", e), 32'(press_pulse), 32'(e == 7));
            check($sformatf("bnc_fb e%0d", e), 32'(button), 32'(e >= 7));
        end

        // Reset while PRESSED: button drops at once, no release strobe
        key_n = 1'b1;
        reset = 1'b1;
        #1;
        check("midrst_button", 32'(button), 32'd0);
        check("midrst_release", 32'(release_pulse), 32'd0);
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("post_r e%0d", e), 32'(release_pulse), 32'd0);
            check($sformatf("post_b e%0d", e), 32'(button), 32'd0);
        end

        // Switch path
        switches_in = 18'h2A5F5;
        #1;
`ifdef BUTTON_DEBOUNCER_SWITCH_SYNC_EN
        check("sw_e0", 32'(switches_out), 32'd0);
        tick();
        check("sw_e1", 32'(switches_out), 32'd0);
        tick();
        check("sw_e2", 32'(switches_out), 32'h2A5F5);
`else
        check("sw_e0", 32'(switches_out), 32'h2A5F5);
        tick();
        check("sw_e1", 32'(switches_out), 32'h2A5F5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions the raw DE2 push-button and slide switches before they reach the processor's input-capture stage. The block synchronises the active-low `key_n` into the `clock` domain and debounces it with a counter-based state machine. It then presents a clean active-high `button` level, plus one-cycle press and release strobes. `button` and `switches_out` feed directly into the input stage's `button` and `switches` ports.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000, is the number of consecutive stable synchronised samples required to accept a level change (10 ms at 50 MHz). Legal range is 1 to 2^24−1.
- `COUNT_WIDTH`, default 24, is the width of the debounce counter. It must satisfy 2^COUNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- `clock`  in  1  system clock. All state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `key_n`  in  1  raw push-button, active-low, asynchronous to `clock`.
- `switches_in`  in  18  raw slide switches, asynchronous.
- `button`  out  1  debounced level, 1 = pressed.
- `press_pulse`  out  1  one-cycle strobe on the accepted press.
- `release_pulse`  out  1  one-cycle strobe on the accepted release.
- `switches_out`  out  18  switch value presented to the input stage.

## Operation

- Synchroniser: two flops, `key_s1` then `key_s2`, both reset to 1 (idle/released). The FSM samples only `key_s2`.
- Four states, reset state RELEASED:
  - RELEASED: if `key_s2`==0, go to PRESS_PENDING and set count to 0.
  - PRESS_PENDING:
    - if `key_s2`==1, return to RELEASED (glitch rejected, no strobe);
    - else if count==DEBOUNCE_CYCLES−1, go to PRESSED, set `button`<=1 and `press_pulse`<=1;
    - else count+1.
  - PRESSED: if `key_s2`==1, go to RELEASE_PENDING and set count to 0.
  - RELEASE_PENDING:
    - if `key_s2`==0, return to PRESSED (no strobe);
    - else if count==DEBOUNCE_CYCLES−1, go to RELEASED, set `button`<=0 and `release_pulse`<=1;
    - else count+1.
- Counter rules: the counter is unsigned, clears on every pending-state entry, never wraps, and holds its value in RELEASED and PRESSED.
- Strobes are registered and default to 0 every cycle. `press_pulse` and `release_pulse` are never high in the same cycle.
- `button` is a registered output that changes only on PRESSED/RELEASED entry.

## Timing

- Reset values: `button`=0, `press_pulse`=0, `release_pulse`=0, `switches_out`=0, state=RELEASED, count=0, `key_s1`=`key_s2`=1.
- Press latency: with `key_n` stable low from rising edge E1, `button` and `press_pulse` rise after edge E(DEBOUNCE_CYCLES+3). Release latency is identical.
- Bounce rule: any opposite sample in a pending state aborts it. Acceptance requires DEBOUNCE_CYCLES consecutive agreeing `key_s2` samples.
- Reset mid-operation: the block returns to RELEASED immediately and asynchronously, and `button` drops to 0 with no `release_pulse`.
- Key held through reset deassertion: treated as a fresh press, so `press_pulse` fires after the full latency.
- DEBOUNCE_CYCLES=1 yields a 4-edge latency.

## Configuration

- `BUTTON_DEBOUNCER_SWITCH_SYNC_EN`
  - Defined: each bit of `switches_in` passes through its own two-flop synchroniser (reset 0), and `switches_out` is the second stage. It has 2-cycle latency and is not debounced.
  - Undefined: `switches_out` = `switches_in` combinationally, with no flops. The reset value of `switches_out` then follows the input.

## Test plan

- Reset: assert `reset` with `key_n`=0 → all outputs 0 while reset is high. After release, `press_pulse` rises after edge 7 (DEBOUNCE_CYCLES=4), counting edges from reset release.
- Clean press: DEBOUNCE_CYCLES=4, `key_n` 1→0 held → `button`=1 and `press_pulse`=1 for exactly one cycle, after edge 7. `button` stays 1.
- Bounce: from a settled release, `key_n` toggles 0,1,0,1 each 2 cycles, then holds 0 → no strobe during bouncing. `press_pulse` fires 7 edges after the final fall.
- Clean release: from PRESSED, `key_n` 0→1 held → `button`=0 and `release_pulse`=1 for one cycle, after edge 7.
- Reset mid-press: assert `reset` while in PRESSED → `button`=0 immediately, with no `release_pulse`.
- Switch path:
  - with `BUTTON_DEBOUNCER_SWITCH_SYNC_EN`: `switches_in`=18'h2A5F5 → `switches_out`=18'h2A5F5 after 2 edges;
  - without it: same cycle.
